// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory controller: FSM encoding, memory geometry
// and the load burst limit.
package dmem_pkg;

    localparam int DMEM_DEPTH = 1024;
    localparam int DMEM_WIDTH = 32;
    localparam int MAX_BURST  = 8;
    localparam int CNT_W      = $clog2(MAX_BURST);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

endpackage

// File: rtl/dmem_ctrl.sv
// Initiator-side controller for the single-port data memory: single-word stores,
// pipelined 1..8 word load bursts, and range errors that never touch the memory.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int SIZE  = DMEM_WIDTH,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [SIZE-1:0] req_addr,
    input  logic [2:0]      req_len,
    input  logic [SIZE-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [SIZE-1:0] rsp_rdata,
    output logic            rsp_last,
    output logic            rsp_err,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_din,
    output logic            mem_wr_rd,
    output logic            mem_cs,
    input  logic [SIZE-1:0] mem_dout
);

    localparam logic [SIZE:0] LIMIT = (SIZE+1)'(DEPTH);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [SIZE-1:0]  r_addr;
    logic [SIZE-1:0]  r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rd_vld;
    logic             r_rd_last;
    logic             r_wr_ack;
    logic             w_accept;
    logic [SIZE:0]    w_last_addr;
    logic             w_range_err;

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and the requester
    // holds its request unchanged until that edge.
    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    // The extra top bit catches addresses that would wrap the SIZE-bit space.
    assign w_last_addr = {1'b0, req_addr} + {{(SIZE-2){1'b0}}, (req_we ? 3'd0 : req_len)};
    assign w_range_err = (w_last_addr >= LIMIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_range_err ? ERR : (req_we ? WRITE : READ);
            WRITE:   w_next = IDLE;
            READ:    if (r_cnt == '0) w_next = DRAIN;
            DRAIN:   w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_wr_ack  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_vld  <= (r_state == READ);
            r_rd_last <= (r_state == READ) && (r_cnt == '0);
            r_wr_ack  <= (r_state == WRITE);
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= req_len;
            end else if (r_state == READ) begin
                r_addr <= r_addr + SIZE'(1);
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Pins decode straight from state so an async reset idles them immediately.
    assign mem_cs    = (r_state == WRITE) || (r_state == READ);
    assign mem_wr_rd = (r_state == READ);
    assign mem_addr  = mem_cs ? r_addr : '0;
    assign mem_din   = (r_state == WRITE) ? r_wdata : '0;

    assign rsp_err   = (r_state == ERR);
    assign rsp_valid = r_rd_vld || r_wr_ack || rsp_err;
    assign rsp_last  = r_rd_last || r_wr_ack || rsp_err;
    assign rsp_rdata = r_rd_vld ? mem_dout : '0;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Initiator-side controller for the single-port data memory (1 Kword × 32, write on `cs=1 & WR_RD=0`, registered read on `WR_RD=1`). It accepts load/store requests from the CPU datapath over a valid/ready handshake and sequences the memory control pins. It issues pipelined read bursts of 1–8 words and returns read data with a last-beat flag. Range errors are reported without touching memory.

## Interface
- `SIZE`, 32, data/address word width
- `DEPTH`, 1024, memory depth in words (word-addressed)
- `clk`  in  1  rising-edge clock, shared with the data memory
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (high only in IDLE)
- `req_we`  in  1  1 = store (single word), 0 = load
- `req_addr`  in  SIZE  word address of first beat
- `req_len`  in  3  load beats minus 1 (0..7); ignored for stores
- `req_wdata`  in  SIZE  store data
- `rsp_valid`  out  1  response beat valid (no backpressure; consumer must take it)
- `rsp_rdata`  out  SIZE  load data; 0 for store ack/error
- `rsp_last`  out  1  final beat of the transaction
- `rsp_err`  out  1  range error (with `rsp_valid`, `rsp_last`)
- `mem_addr`  out  SIZE  to memory ADDR
- `mem_din`  out  SIZE  to memory din
- `mem_wr_rd`  out  1  to memory WR_RD (1 = read)
- `mem_cs`  out  1  to memory cs
- `mem_dout`  in  SIZE  from memory dout

## Operation
- States: IDLE, WRITE, READ, DRAIN, ERR.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch `req_we`, `req_addr`, `req_len`, `req_wdata`.
  - Range check: last address = `req_addr + (req_we ? 0 : req_len)`, computed in SIZE+1 bits. If it is ≥ DEPTH, go to ERR.
  - Otherwise go to WRITE (store) or READ (load). Beat counter = `req_len`.
- WRITE: drive `mem_cs=1`, `mem_wr_rd=0`, `mem_addr`, `mem_din`. Then go to IDLE. Ack beat next cycle: `rsp_valid=1`, `rsp_last=1`, `rsp_rdata=0`.
- READ: drive `mem_cs=1`, `mem_wr_rd=1`, `mem_addr` = base + beat index. Increment the address each cycle. Stay until the counter hits 0, then go to DRAIN.
- DRAIN: memory pins idle; the last data beat is returned. Next state IDLE.
- ERR: pins idle; `rsp_valid=1`, `rsp_err=1`, `rsp_last=1`, `rsp_rdata=0`. Next state IDLE.
- Idle pin state (IDLE, DRAIN, ERR, reset): `mem_cs=0`, `mem_wr_rd=0`, `mem_addr=0`, `mem_din=0`. This combination is a no-op at the memory.
- Read data path: `rsp_valid` is the one-cycle-delayed read-issue flag. `rsp_rdata = mem_dout` when valid, else 0.
- Addresses never wrap; any overflow past DEPTH-1 is an error.
- `req_valid` outside IDLE is ignored; the request must be held until accepted.

## Timing
- Cycle 0 = handshake cycle (`req_valid & req_ready`).
- Store: memory write at end of cycle 1; ack in cycle 2; `req_ready=1` again in cycle 2.
- Load of N beats:
  - Reads issued in cycles 1..N.
  - `rsp_valid` in cycles 2..N+1, one beat per cycle, in address order.
  - `rsp_last` in cycle N+1.
  - `req_ready=1` in cycle N+2 (DRAIN occupies N+1).
- Error: `rsp_err` pulse in cycle 1; `req_ready=1` in cycle 2; no memory pin activity.
- Reset values, all outputs: `req_ready=1`, all `rsp_*`=0, all `mem_*`=0. State IDLE, counters 0.
- Reset mid-burst: pins go idle immediately (asynchronously). No further `rsp_valid`. The partial burst is dropped, and no `rsp_last` is issued for it.
- Throughput: a store every 2 cycles; an N-beat load every N+2 cycles.

## Structure
- Shared package `dmem_pkg`:
  - State encoding (`IDLE`, `WRITE`, `READ`, `DRAIN`, `ERR`)
  - `DMEM_DEPTH = 1024`, `DMEM_WIDTH = 32`
  - `MAX_BURST = 8`
- Single module. The range checker is small enough to stay inline; no sub-module.

## Test plan
- Memory preloaded with words 0..3 = 2001, 4001, 5001, 3001. Load addr 0, len 3 → `rsp_rdata` 2001, 4001, 5001, 3001 in cycles 2–5; `rsp_last` in cycle 5; `req_ready` high in cycle 6.
- Store 0xDEADBEEF to addr 10 → `mem_cs=1`, `mem_wr_rd=0`, `mem_addr=10` in cycle 1; ack in cycle 2. Then load addr 10, len 0 → 0xDEADBEEF, `rsp_last=1`.
- Load addr 1022, len 3 → `rsp_err=1` in cycle 1; `mem_cs` never asserted. Load addr 1023, len 0 → 0, no error.
- Store to addr 1024 → `rsp_err=1`; memory unchanged.
- Assert `rst` in cycle 3 of an 8-beat load from addr 0 → all `mem_*` and `rsp_*` go to 0 at once. After release, `req_ready=1` and a fresh load of addr 1 returns 4001.
- Back-to-back: store 7 to addr 4, then immediately load addr 4, len 0 with `req_valid` held → load accepted in cycle 2, returns 7 in cycle 4; `req_ready` low in cycles 1 and 3–4.
